spi_slave_regs: RTL and testbench

Synthesizable SPI slave with a 16 × 8-bit register file. It sits directly downstream of the AHB SPI master and consumes its `spi_clk`/`spi_mosi`/`spi_nss[n]` lines, returning `spi_miso`. It serves as the on-chip loopback target for the SPI controller and as a reusable control-register port for SPI-attached peripherals. All SPI pins are oversampled in the single system clock domain; there is no SPI-clock domain.

---
 rtl/spi_slave_regs.sv | 206 ++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI slave (modes 0-3) fronting a 16 x 8-bit register file, pins oversampled on hclk.
// Latency: pin edge acted on 3 hclk later; regs_o/wr_pulse_o update 1 cycle after the completing sample edge.
// Backpressure: none; the SPI master must keep half-periods >= 4 hclk cycles.
module spi_slave_regs #(
    parameter int         NREG = 16,
    parameter logic [7:0] ID   = 8'hA5
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_nss,
    output logic              spi_miso,
    input  logic              cpol_i,
    input  logic              cpha_i,
    output logic [8*NREG-1:0] regs_o,
    output logic              wr_pulse_o,
    output logic [3:0]        wr_addr_o,
    output logic              busy_o
);

    localparam logic [NREG-1:0][7:0] REGS_RST = {{(8*(NREG-1)){1'b0}}, ID};

    // pin synchronizers and edge history
    logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_h_q, sclk_h_d;
    logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic nss_s1_q, nss_s1_d, nss_s2_q, nss_s2_d, nss_h_q, nss_h_d;

    // frame state
    logic                  valid_q, valid_d;
    logic                  armed_q, armed_d;
    logic                  frame_q, frame_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            rx_sr_q, rx_sr_d;
    logic                  have_cmd_q, have_cmd_d;
    logic                  is_read_q, is_read_d;
    logic                  byte_seen_q, byte_seen_d;
    logic [3:0]            ptr_q, ptr_d;
    logic [7:0]            tx_sr_q, tx_sr_d;
    logic [7:0]            nxt_q, nxt_d;
    logic                  miso_r_q, miso_r_d;
    logic [NREG-1:0][7:0]  regs_q, regs_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [3:0]            wr_addr_q, wr_addr_d;

    logic       sclk_chg, lead_edge, trail_edge, sample_edge, shift_edge;
    logic       nss_fall, active;
    logic [7:0] rx_byte, nxt_byte;

    always_comb begin
        sclk_s1_d = spi_clk;
        sclk_s2_d = sclk_s1_q;
        sclk_h_d  = sclk_s2_q;
        mosi_s1_d = spi_mosi;
        mosi_s2_d = mosi_s1_q;
        nss_s1_d  = spi_nss;
        nss_s2_d  = nss_s1_q;
        nss_h_d   = nss_s2_q;
    end

    always_comb begin
        sclk_chg    = sclk_s2_q ^ sclk_h_q;
        lead_edge   = sclk_chg & (sclk_s2_q ^ cpol_i);
        trail_edge  = sclk_chg & ~(sclk_s2_q ^ cpol_i);
        sample_edge = cpha_i ? trail_edge : lead_edge;
        shift_edge  = cpha_i ? lead_edge : trail_edge;
        nss_fall    = nss_h_q & ~nss_s2_q;
        active      = frame_q & ~nss_s2_q;
        rx_byte     = {rx_sr_q, mosi_s2_q};
    end

    always_comb begin
        valid_d     = 1'b1;
        // A frame may only start after NSS has been genuinely seen high since reset.
        armed_d     = armed_q | (valid_q & nss_s1_q);
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        have_cmd_d  = have_cmd_q;
        is_read_d   = is_read_q;
        byte_seen_d = byte_seen_q;
        ptr_d       = ptr_q;
        tx_sr_d     = tx_sr_q;
        nxt_d       = nxt_q;
        miso_r_d    = miso_r_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        nxt_byte    = 8'h00;

        if (nss_s2_q) begin
            // Deselected: drop any partial byte; this also wins over a same-cycle byte completion.
            frame_d     = 1'b0;
            bit_cnt_d   = 3'd0;
            rx_sr_d     = 7'd0;
            have_cmd_d  = 1'b0;
            is_read_d   = 1'b0;
            byte_seen_d = 1'b0;
            ptr_d       = 4'd0;
            tx_sr_d     = 8'h00;
            nxt_d       = 8'h00;
            miso_r_d    = 1'b0;
        end else if (!frame_q) begin
            if (nss_fall && armed_q) begin
                frame_d = 1'b1;
                tx_sr_d = 8'h00;
            end
        end else begin
            if (sample_edge) begin
                rx_sr_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_seen_d = 1'b1;
                    if (!have_cmd_q) begin
                        have_cmd_d = 1'b1;
                        is_read_d  = rx_byte[7];
                        ptr_d      = rx_byte[3:0];
                    end else begin
                        if (!is_read_q && ptr_q != 4'd0) begin
                            regs_d[ptr_q] = rx_byte;
                            wr_pulse_d    = 1'b1;
                            wr_addr_d     = ptr_q;
                        end
                        ptr_d = ptr_q + 4'd1;
                    end
                    nxt_byte = is_read_d ? regs_q[ptr_d] : 8'h00;
                    // CPHA=1 needs the byte now; CPHA=0 holds it until the following shift edge.
                    if (cpha_i) begin
                        tx_sr_d = nxt_byte;
                    end else begin
                        nxt_d = nxt_byte;
                    end
                end
            end
            if (shift_edge) begin
                if (cpha_i) begin
                    miso_r_d = tx_sr_q[7];
                    tx_sr_d  = {tx_sr_q[6:0], 1'b0};
                end else if (bit_cnt_q == 3'd0 && byte_seen_q) begin
                    tx_sr_d = nxt_q;
                end else begin
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sclk_s1_q   <= cpol_i;
            sclk_s2_q   <= cpol_i;
            sclk_h_q    <= cpol_i;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            nss_s1_q    <= 1'b1;
            nss_s2_q    <= 1'b1;
            nss_h_q     <= 1'b1;
            valid_q     <= 1'b0;
            armed_q     <= 1'b0;
            frame_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'd0;
            have_cmd_q  <= 1'b0;
            is_read_q   <= 1'b0;
            byte_seen_q <= 1'b0;
            ptr_q       <= 4'd0;
            tx_sr_q     <= 8'h00;
            nxt_q       <= 8'h00;
            miso_r_q    <= 1'b0;
            regs_q      <= REGS_RST;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= 4'd0;
        end else begin
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_h_q    <= sclk_h_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            nss_s1_q    <= nss_s1_d;
            nss_s2_q    <= nss_s2_d;
            nss_h_q     <= nss_h_d;
            valid_q     <= valid_d;
            armed_q     <= armed_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            have_cmd_q  <= have_cmd_d;
            is_read_q   <= is_read_d;
            byte_seen_q <= byte_seen_d;
            ptr_q       <= ptr_d;
            tx_sr_q     <= tx_sr_d;
            nxt_q       <= nxt_d;
            miso_r_q    <= miso_r_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign spi_miso   = active & (cpha_i ? miso_r_q : tx_sr_q[7]);
    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_addr_o  = wr_addr_q;
    assign busy_o     = ~nss_s2_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: table of SPI frames plus hand-written corner sequences.
// Latency: drives pins on hclk falling edges with a 4-cycle SPI half-period.
// Backpressure: none; all waits are fixed cycle counts.
module tb_spi_slave_regs;

    localparam int H = 4;
    localparam logic [127:0] REGS_RST = {120'h0, 8'hA5};

    logic         hclk = 1'b0;
    logic         hresetn = 1'b0;
    logic         spi_clk = 1'b0;
    logic         spi_mosi = 1'b0;
    logic         spi_nss = 1'b1;
    logic         cpol_i = 1'b0;
    logic         cpha_i = 1'b0;
    logic         spi_miso;
    logic [127:0] regs_o;
    logic         wr_pulse_o;
    logic [3:0]   wr_addr_o;
    logic         busy_o;

    spi_slave_regs dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_nss    (spi_nss),
        .spi_miso   (spi_miso),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .wr_addr_o  (wr_addr_o),
        .busy_o     (busy_o)
    );

    always #5 hclk = ~hclk;

    int         checks = 0;
    int         failures = 0;
    int         pulse_cnt = 0;
    logic [3:0] pulse_addr [64];
    logic [7:0] tx_buf [3];
    logic [7:0] rx_buf [3];

    always @(negedge hclk) begin
        if (wr_pulse_o) begin
            if (pulse_cnt < 64) pulse_addr[pulse_cnt] = wr_addr_o;
            pulse_cnt = pulse_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       pol;
        logic       pha;
        int         nbits;
        logic [7:0] tx0, tx1, tx2;
        logic [7:0] rx1, rx2;
        int         pulses;
        int         a1;
        logic [7:0] v1;
        int         a2;
        logic [7:0] v2;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s[%0d]: actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic spi_bit(input logic pol, input logic pha, input logic b, output logic r);
        if (!pha) begin
            spi_mosi = b;
            repeat (H) @(negedge hclk);
            r = spi_miso;
            spi_clk = ~pol;
            repeat (H) @(negedge hclk);
            spi_clk = pol;
        end else begin
            spi_clk = ~pol;
            spi_mosi = b;
            repeat (H) @(negedge hclk);
            r = spi_miso;
            spi_clk = pol;
            repeat (H) @(negedge hclk);
        end
    endtask

    task automatic spi_frame(input logic pol, input logic pha, input int nbits);
        logic r;
        cpol_i = pol;
        cpha_i = pha;
        spi_clk = pol;
        spi_mosi = 1'b0;
        repeat (4) @(negedge hclk);
        for (int i = 0; i < 3; i++) rx_buf[i] = 8'h00;
        spi_nss = 1'b0;
        repeat (H) @(negedge hclk);
        for (int b = 0; b < nbits; b++) begin
            spi_bit(pol, pha, tx_buf[b / 8][7 - (b % 8)], r);
            rx_buf[b / 8][7 - (b % 8)] = r;
        end
        repeat (H) @(negedge hclk);
        spi_nss = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(negedge hclk);
    endtask

    initial begin
        int   p0;
        logic r;

        vecs[0]  = '{1'b0, 1'b0, 24, 8'h03, 8'h11, 8'h22, 8'h00, 8'h00, 2, 3,  8'h11, 4, 8'h22};
        vecs[1]  = '{1'b1, 1'b1, 24, 8'h83, 8'h00, 8'h00, 8'h11, 8'h22, 0, 3,  8'h11, 4, 8'h22};
        vecs[2]  = '{1'b0, 1'b0, 13, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 5,  8'h00, 6, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 16, 8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 0, 5,  8'h00, 0, 8'hA5};
        vecs[4]  = '{1'b0, 1'b0, 24, 8'h0F, 8'hAA, 8'hBB, 8'h00, 8'h00, 1, 15, 8'hAA, 0, 8'hA5};
        vecs[5]  = '{1'b0, 1'b0, 24, 8'h8F, 8'h00, 8'h00, 8'hAA, 8'hA5, 0, 15, 8'hAA, 1, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 24, 8'h02, 8'h5C, 8'h30, 8'h00, 8'h00, 2, 2,  8'h5C, 3, 8'h30};
        vecs[7]  = '{1'b0, 1'b0, 24, 8'h82, 8'h00, 8'h00, 8'h5C, 8'h30, 0, 2,  8'h5C, 3, 8'h30};
        vecs[8]  = '{1'b0, 1'b1, 24, 8'h02, 8'h5C, 8'h31, 8'h00, 8'h00, 2, 2,  8'h5C, 3, 8'h31};
        vecs[9]  = '{1'b0, 1'b1, 24, 8'h82, 8'h00, 8'h00, 8'h5C, 8'h31, 0, 2,  8'h5C, 3, 8'h31};
        vecs[10] = '{1'b1, 1'b0, 24, 8'h02, 8'h5C, 8'h32, 8'h00, 8'h00, 2, 2,  8'h5C, 3, 8'h32};
        vecs[11] = '{1'b1, 1'b0, 24, 8'h82, 8'h00, 8'h00, 8'h5C, 8'h32, 0, 2,  8'h5C, 3, 8'h32};
        vecs[12] = '{1'b1, 1'b1, 24, 8'h02, 8'h5C, 8'h33, 8'h00, 8'h00, 2, 2,  8'h5C, 3, 8'h33};
        vecs[13] = '{1'b1, 1'b1, 24, 8'h82, 8'h00, 8'h00, 8'h5C, 8'h33, 0, 2,  8'h5C, 3, 8'h33};

        // reset state
        repeat (3) @(negedge hclk);
        chk("rst_regs", 0, regs_o, REGS_RST);
        chk("rst_miso", 0, spi_miso, 0);
        chk("rst_pulse", 0, wr_pulse_o, 0);
        chk("rst_addr", 0, wr_addr_o, 0);
        chk("rst_busy", 0, busy_o, 0);
        hresetn = 1'b1;
        repeat (6) @(negedge hclk);

        for (int v = 0; v < 14; v++) begin
            p0 = pulse_cnt;
            tx_buf[0] = vecs[v].tx0;
            tx_buf[1] = vecs[v].tx1;
            tx_buf[2] = vecs[v].tx2;
            spi_frame(vecs[v].pol, vecs[v].pha, vecs[v].nbits);
            chk("rx0", v, rx_buf[0], 8'h00);
            if (vecs[v].nbits >= 16) chk("rx1", v, rx_buf[1], vecs[v].rx1);
            if (vecs[v].nbits >= 24) chk("rx2", v, rx_buf[2], vecs[v].rx2);
            chk("pulses", v, pulse_cnt - p0, vecs[v].pulses);
            chk("reg_a1", v, regs_o[vecs[v].a1 * 8 +: 8], vecs[v].v1);
            chk("reg_a2", v, regs_o[vecs[v].a2 * 8 +: 8], vecs[v].v2);
            if (v == 0) begin
                chk("wr_addr_first", v, pulse_addr[p0], 4'd3);
                chk("wr_addr_second", v, pulse_addr[p0 + 1], 4'd4);
            end
        end

        // NSS rises together with the completing sample edge: byte dropped
        cpol_i = 1'b0;
        cpha_i = 1'b0;
        spi_clk = 1'b0;
        repeat (4) @(negedge hclk);
        p0 = pulse_cnt;
        tx_buf[0] = 8'h07;
        tx_buf[1] = 8'h99;
        spi_nss = 1'b0;
        repeat (H) @(negedge hclk);
        for (int b = 0; b < 15; b++) spi_bit(1'b0, 1'b0, tx_buf[b / 8][7 - (b % 8)], r);
        spi_mosi = 1'b1;
        repeat (H) @(negedge hclk);
        spi_clk = 1'b1;
        spi_nss = 1'b1;
        repeat (8) @(negedge hclk);
        spi_clk = 1'b0;
        repeat (8) @(negedge hclk);
        chk("collide_pulses", 0, pulse_cnt - p0, 0);
        chk("collide_reg7", 0, regs_o[7 * 8 +: 8], 8'h00);
        chk("collide_wr_addr", 0, wr_addr_o, 4'd3);

        // reset in the middle of a mode 1 frame
        cpol_i = 1'b0;
        cpha_i = 1'b1;
        repeat (4) @(negedge hclk);
        tx_buf[0] = 8'h09;
        tx_buf[1] = 8'h66;
        tx_buf[2] = 8'hF0;
        spi_nss = 1'b0;
        repeat (H) @(negedge hclk);
        for (int b = 0; b < 20; b++) spi_bit(1'b0, 1'b1, tx_buf[b / 8][7 - (b % 8)], r);
        chk("mid_busy", 0, busy_o, 1);
        chk("mid_reg9", 0, regs_o[9 * 8 +: 8], 8'h66);
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        chk("mid_rst_regs", 0, regs_o, REGS_RST);
        chk("mid_rst_miso", 0, spi_miso, 0);
        chk("mid_rst_pulse", 0, wr_pulse_o, 0);
        chk("mid_rst_addr", 0, wr_addr_o, 0);
        chk("mid_rst_busy", 0, busy_o, 0);
        hresetn = 1'b1;
        repeat (4) @(negedge hclk);

        // NSS still low after reset: clocks must be ignored until a fresh fall
        p0 = pulse_cnt;
        tx_buf[0] = 8'h0A;
        tx_buf[1] = 8'h44;
        for (int b = 0; b < 16; b++) spi_bit(1'b0, 1'b1, tx_buf[b / 8][7 - (b % 8)], r);
        repeat (8) @(negedge hclk);
        chk("stale_pulses", 0, pulse_cnt - p0, 0);
        chk("stale_reg10", 0, regs_o[10 * 8 +: 8], 8'h00);
        spi_nss = 1'b1;
        repeat (8) @(negedge hclk);

        p0 = pulse_cnt;
        spi_frame(1'b0, 1'b1, 16);
        chk("fresh_pulses", 0, pulse_cnt - p0, 1);
        chk("fresh_reg10", 0, regs_o[10 * 8 +: 8], 8'h44);
        chk("fresh_wr_addr", 0, wr_addr_o, 4'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
